nand_onfi_master: RTL and testbench

Host-side controller for an ONFI-style asynchronous NAND flash device with an 8-bit data path on a 16-bit bus. A host issues 8-bit command codes on cmd_in, qualified by a one-cycle activate pulse. The block then drives the NAND control pins (CE#, CLE, ALE, WE#, RE#, WP#) with parameterised cycle timing, captures ID and status bytes into internal buffers, and returns them one byte at a time on data_out.

---
 rtl/nand_onfi_master.sv | 228 ++++++++++++++++++++++
 tb/tb_nand_onfi_master.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_onfi_master.sv
// Host-side master for an ONFI-style asynchronous NAND device (8-bit data on a 16-bit bus).
module nand_onfi_master #(
  parameter int unsigned T_WP     = 4,
  parameter int unsigned T_WH     = 4,
  parameter int unsigned T_WHR    = 60,
  parameter int unsigned T_RP     = 8,
  parameter int unsigned T_REH    = 8,
  parameter int unsigned T_WB     = 8,
  parameter int unsigned ID_BYTES = 5
) (
  input  logic        clk,
  input  logic        nreset,
  output logic        nand_cle,
  output logic        nand_ale,
  output logic        nand_nwe,
  output logic        nand_nwp,
  output logic        nand_nce,
  output logic        nand_nre,
  input  logic        nand_rnb,
  inout  logic [15:0] nand_data,
  output logic [7:0]  data_out,
  input  logic [7:0]  data_in,
  output logic        busy,
  input  logic        activate,
  input  logic [7:0]  cmd_in
);

  localparam int unsigned CW = 16;
  localparam int unsigned IW = (ID_BYTES > 1) ? $clog2(ID_BYTES) : 1;

  localparam logic [CW-1:0] LATCH_LAST = CW'(T_WP + T_WH - 1);
  localparam logic [CW-1:0] WP_CNT     = CW'(T_WP);
  localparam logic [CW-1:0] WHR_LAST   = CW'(T_WHR - 1);
  localparam logic [CW-1:0] RP_LAST    = CW'(T_RP - 1);
  localparam logic [CW-1:0] REH_LAST   = CW'(T_REH - 1);
  localparam logic [CW-1:0] WB_LAST    = CW'(T_WB - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(ID_BYTES - 1);

  localparam logic [7:0] CMD_RESET       = 8'h01;
  localparam logic [7:0] CMD_READ_ID     = 8'h03;
  localparam logic [7:0] CMD_READ_STATUS = 8'h05;
  localparam logic [7:0] CMD_CE_OFF      = 8'h08;
  localparam logic [7:0] CMD_CE_ON       = 8'h09;
  localparam logic [7:0] CMD_WP_ON       = 8'h0A;
  localparam logic [7:0] CMD_WP_OFF      = 8'h0B;
  localparam logic [7:0] CMD_IDX_CLR     = 8'h0C;
  localparam logic [7:0] CMD_GET_ID      = 8'h0E;
  localparam logic [7:0] CMD_GET_STATUS  = 8'h0F;

  typedef enum logic [3:0] {
    IDLE,
    CMD_LATCH,
    ADDR_LATCH,
    WAIT_WHR,
    READ_LOW,
    READ_HIGH,
    WAIT_WB,
    WAIT_RNB,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] rd_q, rd_d;
  logic [7:0]    lat_q, lat_d;
  logic          oe_q;
  logic          cle_d, ale_d, nwe_d, nre_d, busy_d;

  logic [7:0]    op_q, arg_q, status_q;
  logic [IW-1:0] idx_q;
  logic [7:0]    id_buf [ID_BYTES];
  logic [1:0]    rnb_sync;
  logic          unused_hi;

  assign nand_data = oe_q ? {8'h00, lat_q} : 'z;
  assign unused_hi = ^nand_data[15:8];

  // Pin outputs are decoded from the next state so they leave the flops glitch-free.
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_q     <= '0;
      lat_q    <= '0;
      oe_q     <= 1'b0;
      nand_cle <= 1'b0;
      nand_ale <= 1'b0;
      nand_nwe <= 1'b1;
      nand_nre <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      lat_q    <= lat_d;
      oe_q     <= cle_d | ale_d;
      nand_cle <= cle_d;
      nand_ale <= ale_d;
      nand_nwe <= nwe_d;
      nand_nre <= nre_d;
      busy     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    rd_d    = rd_q;
    lat_d   = lat_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        rd_d  = '0;
        if (activate) begin
          state_d = DONE;
          if (!nand_nce) begin
            case (cmd_in)
              CMD_RESET:       begin state_d = CMD_LATCH; lat_d = 8'hFF; end
              CMD_READ_ID:     begin state_d = CMD_LATCH; lat_d = 8'h90; end
              CMD_READ_STATUS: begin state_d = CMD_LATCH; lat_d = 8'h70; end
              default: ;
            endcase
          end
        end
      end
      CMD_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          cnt_d = '0;
          case (op_q)
            CMD_RESET:   state_d = WAIT_WB;
            CMD_READ_ID: begin state_d = ADDR_LATCH; lat_d = arg_q; end
            default:     state_d = WAIT_WHR;
          endcase
        end
      end
      ADDR_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          cnt_d   = '0;
          state_d = WAIT_WHR;
        end
      end
      WAIT_WHR: begin
        if (cnt_q == WHR_LAST) begin
          cnt_d   = '0;
          state_d = READ_LOW;
        end
      end
      READ_LOW: begin
        if (cnt_q == RP_LAST) begin
          cnt_d   = '0;
          state_d = READ_HIGH;
        end
      end
      READ_HIGH: begin
        if (cnt_q == REH_LAST) begin
          cnt_d = '0;
          if (op_q == CMD_READ_ID && rd_q != IDX_LAST) begin
            rd_d    = rd_q + 1'b1;
            state_d = READ_LOW;
          end else begin
            state_d = DONE;
          end
        end
      end
      WAIT_WB: begin
        if (cnt_q == WB_LAST) begin
          cnt_d   = '0;
          state_d = WAIT_RNB;
        end
      end
      WAIT_RNB: begin
        cnt_d = '0;
        if (rnb_sync[1]) state_d = DONE;
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cle_d  = (state_d == CMD_LATCH);
    ale_d  = (state_d == ADDR_LATCH);
    nwe_d  = !((cle_d || ale_d) && (cnt_d < WP_CNT));
    nre_d  = (state_d != READ_LOW);
    busy_d = (state_d != IDLE);
  end

  // Command latching, internal commands, read capture and the ready/busy synchroniser.
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      op_q     <= '0;
      arg_q    <= '0;
      status_q <= '0;
      idx_q    <= '0;
      data_out <= '0;
      nand_nce <= 1'b1;
      nand_nwp <= 1'b0;
      rnb_sync <= '0;
      id_buf   <= '{default: '0};
    end else begin
      rnb_sync <= {rnb_sync[0], nand_rnb};
      if (state_q == IDLE && activate) begin
        op_q  <= cmd_in;
        arg_q <= data_in;
        case (cmd_in)
          CMD_CE_OFF:     nand_nce <= 1'b1;
          CMD_CE_ON:      nand_nce <= 1'b0;
          CMD_WP_ON:      nand_nwp <= 1'b0;
          CMD_WP_OFF:     nand_nwp <= 1'b1;
          CMD_IDX_CLR:    idx_q    <= '0;
          CMD_GET_ID: begin
            data_out <= id_buf[idx_q];
            idx_q    <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end
          CMD_GET_STATUS: data_out <= status_q;
          default: ;
        endcase
      end
      if (state_q == READ_LOW && cnt_q == RP_LAST) begin
        if (op_q == CMD_READ_ID) id_buf[rd_q] <= nand_data[7:0];
        else                     status_q     <= nand_data[7:0];
      end
      if (state_q == READ_HIGH && cnt_q == REH_LAST && op_q == CMD_READ_ID && rd_q == IDX_LAST)
        idx_q <= '0;
    end
  end

endmodule

// File: tb/tb_nand_onfi_master.sv
// Self-checking bench for nand_onfi_master against a phase-schedule reference model.
module tb_nand_onfi_master;

  localparam int T_WP = 4, T_WH = 4, T_WHR = 60, T_RP = 8, T_REH = 8, T_WB = 8, ID_BYTES = 5;
  localparam int K_CLE = 0, K_ALE = 1, K_WAIT = 2, K_READ = 3;

  logic        clk = 1'b0;
  logic        nreset;
  logic        nand_cle, nand_ale, nand_nwe, nand_nwp, nand_nce, nand_nre;
  logic        nand_rnb;
  wire  [15:0] nand_data;
  logic [7:0]  data_out, data_in, cmd_in;
  logic        busy, activate;
  logic        dev_en;
  logic [15:0] dev_val;

  int checks = 0;
  int errors = 0;

  assign nand_data = dev_en ? dev_val : 16'hzzzz;

  always #5 clk = ~clk;

  nand_onfi_master #(
    .T_WP(T_WP), .T_WH(T_WH), .T_WHR(T_WHR), .T_RP(T_RP),
    .T_REH(T_REH), .T_WB(T_WB), .ID_BYTES(ID_BYTES)
  ) dut (
    .clk(clk), .nreset(nreset),
    .nand_cle(nand_cle), .nand_ale(nand_ale), .nand_nwe(nand_nwe), .nand_nwp(nand_nwp),
    .nand_nce(nand_nce), .nand_nre(nand_nre), .nand_rnb(nand_rnb), .nand_data(nand_data),
    .data_out(data_out), .data_in(data_in), .busy(busy), .activate(activate), .cmd_in(cmd_in)
  );

  // Reference model state
  typedef struct {
    int         kind;
    int         len;
    logic [7:0] val;
  } phase_t;

  typedef struct packed {
    logic       cle, ale, nwe, nre, drv, rd, busy;
    logic [7:0] bval;
  } pins_t;

  phase_t     sched[$];
  logic [7:0] id_model [ID_BYTES];
  logic [7:0] status_model;
  int         idx_model;

  function automatic int sched_len();
    int n = 0;
    foreach (sched[i]) n += sched[i].len;
    return n;
  endfunction

  // Expected pin levels k cycles after the command was accepted.
  function automatic pins_t model_at(int k);
    pins_t p;
    int    base = 0;
    int    off;
    p     = '0;
    p.nwe = 1'b1;
    p.nre = 1'b1;
    foreach (sched[i]) begin
      if (k >= base && k < base + sched[i].len) begin
        off    = k - base;
        p.busy = 1'b1;
        p.bval = sched[i].val;
        case (sched[i].kind)
          K_CLE:  begin p.cle = 1'b1; p.drv = 1'b1; p.nwe = (off >= T_WP); end
          K_ALE:  begin p.ale = 1'b1; p.drv = 1'b1; p.nwe = (off >= T_WP); end
          K_READ: begin p.rd = 1'b1; p.nre = (off >= T_RP); end
          default: ;
        endcase
        return p;
      end
      base += sched[i].len;
    end
    if (k == base) p.busy = 1'b1;
    return p;
  endfunction

  task automatic strobe(input logic [7:0] cmd);
    cmd_in   = cmd;
    data_in  = 8'($urandom);
    activate = 1'b1;
    @(negedge clk);
    activate = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    dev_en  = 1'b1;
    dev_val = 16'h5AC3;
    #1;
    checks++;
    if ({nand_nce, nand_nwe, nand_nre, nand_cle, nand_ale, nand_nwp, busy} !== 7'b1110000 ||
        data_out !== 8'h00 || nand_data !== 16'h5AC3) begin
      errors++;
      $display("FAIL reset_values: got nce/nwe/nre/cle/ale/nwp/busy=%b data_out=%h bus=%h, expected 1110000 00 5ac3",
               {nand_nce, nand_nwe, nand_nre, nand_cle, nand_ale, nand_nwp, busy}, data_out, nand_data);
    end
  endtask

  task automatic test_chip_enable();
    cmd_in = 8'h09; activate = 1'b1;
    @(negedge clk);
    activate = 1'b0;
    checks++;
    if (nand_nce !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL ce_on: got nce=%b busy=%b, expected 0 1", nand_nce, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ce_on_busy: got %b, expected 0", busy); end
    strobe(8'h08);
    checks++;
    if (nand_nce !== 1'b1) begin errors++; $display("FAIL ce_off: got %b, expected 1", nand_nce); end
    // NAND command while chip disabled: single busy cycle, no latch cycle
    cmd_in = 8'h05; activate = 1'b1;
    @(negedge clk);
    activate = 1'b0;
    checks++;
    if (busy !== 1'b1 || nand_cle !== 1'b0 || nand_nwe !== 1'b1) begin
      errors++; $display("FAIL ce_off_cmd: got busy=%b cle=%b nwe=%b, expected 1 0 1", busy, nand_cle, nand_nwe);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || nand_cle !== 1'b0) begin
      errors++; $display("FAIL ce_off_cmd_end: got busy=%b cle=%b, expected 0 0", busy, nand_cle);
    end
    strobe(8'h09);
    checks++;
    if (nand_nce !== 1'b0) begin errors++; $display("FAIL ce_reenable: got %b, expected 0", nand_nce); end
  endtask

  // Read ID (0x03) or read status (0x05); inj_k >= 0 pulses a chip-disable strobe mid-sequence.
  task automatic test_nand_read(input logic [7:0] cmd, input logic [7:0] addr, input int inj_k);
    pins_t      p;
    int         total;
    logic [4:0] obs, exp;
    sched.delete();
    if (cmd == 8'h03) begin
      sched.push_back('{K_CLE, T_WP + T_WH, 8'h90});
      sched.push_back('{K_ALE, T_WP + T_WH, addr});
      sched.push_back('{K_WAIT, T_WHR, 8'h00});
      for (int i = 0; i < ID_BYTES; i++) sched.push_back('{K_READ, T_RP + T_REH, id_model[i]});
    end else begin
      sched.push_back('{K_CLE, T_WP + T_WH, 8'h70});
      sched.push_back('{K_WAIT, T_WHR, 8'h00});
      sched.push_back('{K_READ, T_RP + T_REH, status_model});
    end
    total    = sched_len() + 2;
    dev_en   = 1'b0;
    cmd_in   = cmd;
    data_in  = addr;
    activate = 1'b1;
    @(negedge clk);
    activate = 1'b0;
    for (int k = 0; k < total; k++) begin
      p   = model_at(k);
      exp = {p.cle, p.ale, p.nwe, p.nre, p.busy};
      obs = {nand_cle, nand_ale, nand_nwe, nand_nre, busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL read_%h_pins k=%0d: got cle/ale/nwe/nre/busy=%b, expected %b", cmd, k, obs, exp);
      end
      if (p.drv) begin
        checks++;
        if (nand_data !== {8'h00, p.bval}) begin
          errors++;
          $display("FAIL read_%h_bus k=%0d: got %h, expected %h", cmd, k, nand_data, {8'h00, p.bval});
        end
      end
      cmd_in   = 8'h08;
      activate = (k == inj_k);
      p        = model_at(k + 1);
      dev_en   = !p.drv;
      dev_val  = p.rd ? {8'h3C, p.bval} : 16'hC35A;
      @(negedge clk);
    end
    activate = 1'b0;
    checks++;
    if (nand_nce !== 1'b0) begin
      errors++; $display("FAIL read_%h_nce_after: got %b, expected 0", cmd, nand_nce);
    end
    if (cmd == 8'h03) idx_model = 0;
  endtask

  task automatic test_get_id();
    for (int i = 0; i <= ID_BYTES; i++) begin
      cmd_in   = 8'h0E;
      activate = 1'b1;
      @(negedge clk);
      activate = 1'b0;
      checks++;
      if (data_out !== id_model[idx_model] || busy !== 1'b1) begin
        errors++;
        $display("FAIL get_id[%0d]: got data_out=%h busy=%b, expected %h 1", i, data_out, busy, id_model[idx_model]);
      end
      idx_model = (idx_model + 1) % ID_BYTES;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL get_id_busy[%0d]: got %b, expected 0", i, busy); end
    end
  endtask

  task automatic test_index_reset();
    strobe(8'h0E);
    strobe(8'h0E);
    strobe(8'h0C);
    idx_model = 0;
    strobe(8'h0E);
    checks++;
    if (data_out !== id_model[0]) begin
      errors++; $display("FAIL index_reset: got %h, expected %h", data_out, id_model[0]);
    end
    idx_model = 1;
  endtask

  task automatic test_status(input logic [7:0] st);
    status_model = st;
    test_nand_read(8'h05, 8'($urandom), -1);
    strobe(8'h0F);
    checks++;
    if (data_out !== st) begin errors++; $display("FAIL get_status: got %h, expected %h", data_out, st); end
    strobe(8'h0B);
    checks++;
    if (nand_nwp !== 1'b1) begin errors++; $display("FAIL wp_off: got %b, expected 1", nand_nwp); end
    strobe(8'h0A);
    checks++;
    if (nand_nwp !== 1'b0) begin errors++; $display("FAIL wp_on: got %b, expected 0", nand_nwp); end
  endtask

  task automatic test_reset_cmd(input int low_clks);
    pins_t      p;
    int         rise_k;
    bit         fell;
    logic [4:0] obs, exp;
    sched.delete();
    sched.push_back('{K_CLE, T_WP + T_WH, 8'hFF});
    rise_k   = T_WP + T_WH + T_WB + low_clks;
    dev_en   = 1'b0;
    nand_rnb = 1'b0;
    cmd_in   = 8'h01;
    activate = 1'b1;
    @(negedge clk);
    activate = 1'b0;
    for (int k = 0; k <= rise_k + 1; k++) begin
      p   = model_at(k);
      exp = {p.cle, p.ale, p.nwe, p.nre, 1'b1};
      obs = {nand_cle, nand_ale, nand_nwe, nand_nre, busy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_cmd_pins k=%0d: got cle/ale/nwe/nre/busy=%b, expected %b", k, obs, exp);
      end
      if (p.drv) begin
        checks++;
        if (nand_data !== 16'h00FF) begin
          errors++; $display("FAIL reset_cmd_bus k=%0d: got %h, expected 00ff", k, nand_data);
        end
      end
      if (k == rise_k) nand_rnb = 1'b1;
      p       = model_at(k + 1);
      dev_en  = !p.drv;
      dev_val = 16'hC35A;
      @(negedge clk);
    end
    fell = 1'b0;
    for (int n = 0; n < 8 && !fell; n++) begin
      if (busy === 1'b0) fell = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!fell) begin errors++; $display("FAIL reset_cmd_done: got busy=%b after ready, expected 0", busy); end
  endtask

  task automatic test_async_reset();
    int stop_k;
    stop_k   = $urandom_range(1, 150);
    dev_en   = 1'b0;
    cmd_in   = 8'h03;
    data_in  = 8'($urandom);
    activate = 1'b1;
    @(negedge clk);
    activate = 1'b0;
    repeat (stop_k) @(negedge clk);
    nreset  = 1'b1;
    #1;
    dev_en  = 1'b1;
    dev_val = 16'h5AC3;
    #1;
    checks++;
    if ({nand_nce, nand_nwe, nand_nre, nand_cle, nand_ale, nand_nwp, busy} !== 7'b1110000 ||
        data_out !== 8'h00 || nand_data !== 16'h5AC3) begin
      errors++;
      $display("FAIL abort_reset k=%0d: got nce/nwe/nre/cle/ale/nwp/busy=%b data_out=%h bus=%h, expected 1110000 00 5ac3",
               stop_k, {nand_nce, nand_nwe, nand_nre, nand_cle, nand_ale, nand_nwp, busy}, data_out, nand_data);
    end
    @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    strobe(8'h09);
    strobe(8'h0E);
    checks++;
    if (data_out !== 8'h00 || nand_nce !== 1'b0) begin
      errors++; $display("FAIL abort_cleared_id: got data_out=%h nce=%b, expected 00 0", data_out, nand_nce);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset    = 1'b1;
    activate  = 1'b0;
    cmd_in    = 8'h00;
    data_in   = 8'h00;
    nand_rnb  = 1'b1;
    dev_en    = 1'b1;
    dev_val   = 16'h5AC3;
    idx_model = 0;
    repeat (3) @(negedge clk);
    test_reset();
    nreset = 1'b0;
    @(negedge clk);
    test_chip_enable();

    id_model[0] = 8'h2C; id_model[1] = 8'hE5; id_model[2] = 8'hFF;
    id_model[3] = 8'h03; id_model[4] = 8'h86;
    test_nand_read(8'h03, 8'h00, -1);
    test_get_id();

    foreach (id_model[i]) id_model[i] = 8'($urandom);
    test_nand_read(8'h03, 8'($urandom), $urandom_range(1, 150));
    test_get_id();
    test_index_reset();

    test_status(8'hE0);
    test_status(8'($urandom));

    test_reset_cmd(20);
    test_reset_cmd($urandom_range(3, 40));

    test_async_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
